hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core (IF, ID, EX, MEM, WB). It tracks destination registers in flight in EX, MEM and WB with a three-slot scoreboard, and compares them against the source registers of the instruction currently in decode. It drives the PC/IF-ID enables, the IF-ID flush and the ID-EX bubble insert, and freezes the whole pipe while data memory is busy. A saturating stall counter is provided for performance bring-up.

## Interface
Parameters:
- CNT_W, 16, width of the stall-cycle counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- id_rs1  in  5  INSTRUCTION[19:15] in ID
- id_rs2  in  5  INSTRUCTION[24:20] in ID
- id_use_rs2  in  1  instruction reads rs2 (R, S, B types)
- id_rd  in  5  INSTRUCTION[11:7] in ID
- id_reg_write  in  1  control-unit RegWrite for ID instruction
- id_mem_read  in  1  control-unit MemRead for ID instruction
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- mem_busy  in  1  data memory not ready, pipe must hold
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a bubble
- idex_bubble  out  1  ID/EX loads a bubble (control bits zeroed)
- freeze  out  1  all pipeline registers hold
- state  out  2  current FSM state (RUN=0, STALL=1, FREEZE=2)
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0, excluding reset

## Operation
- Scoreboard slots EX, MEM, WB, each {valid, rd, is_load}. Slot valid only if reg_write=1 and rd≠0; x0 never creates a hazard.
- Normal advance: EX←issue{id_valid&id_reg_write&(id_rd≠0), id_rd, id_mem_read}; MEM←EX; WB←MEM.
- On a bubble (stall or flush), EX←invalid while MEM and WB still advance.
- rs1 hit: id_valid and slot.valid and slot.rd==id_rs1. rs2 hit: the same test against id_rs2, gated by id_use_rs2.
- hazard, with forwarding: hit in EX slot with is_load=1.
- hazard, without forwarding: hit in any of EX, MEM or WB. The register file writes at the end of WB, so a WB match still stalls.
- Priority, high to low: mem_busy, ex_branch_taken, hazard, run.
- FREEZE (mem_busy=1): freeze=1, pc_en=0, ifid_en=0, ifid_flush=0, idex_bubble=0. The scoreboard holds and ex_branch_taken is ignored. The branch remains in EX and is acted on when mem_busy drops.
- Branch taken (mem_busy=0): pc_en=1, ifid_flush=1, idex_bubble=1. This overrides any concurrent hazard.
- Hazard: pc_en=0, ifid_en=0, idex_bubble=1.
- Run: pc_en=1, ifid_en=1, flush=0, bubble=0.
- FSM state is registered and reflects the priority decision of the previous cycle. RUN→STALL on hazard, STALL→RUN when the hazard clears, any→FREEZE on mem_busy, FREEZE→RUN or STALL per the next decision.
- stall_cnt increments when pc_en=0 and rst=0, and saturates at all-ones.

## Timing
- Hazard detection is combinational: enables react in the same cycle the instruction sits in ID.
- Stall length without forwarding: producer in EX gives 3 cycles, in MEM 2, in WB 1.
- Stall length with forwarding: load immediately ahead gives 1 cycle, all other cases 0.
- Flush is one cycle only. The wrong-path instruction in ID is killed by the bubble and never enters the scoreboard.
- Reset state: scoreboard cleared, state=RUN, stall_cnt=0.
- While rst=1, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, freeze=0.
- Reset mid-stall or mid-freeze drops all in-flight tracking. The first cycle after reset runs with no hazards.

## Configuration
- FORWARD_EN defined: the EX/MEM→EX forwarding network exists, and only load-use hazards stall.
- FORWARD_EN undefined: full interlock across the EX, MEM and WB slots; is_load is unused.

## Structure
- Package hazard_pkg holds:
  - slot_t struct {valid, rd[4:0], is_load}
  - state_t enum (RUN, STALL, FREEZE)
  - constant REG_ZERO=5'd0
- Sub-module hazard_scoreboard contains the three slots, shift/bubble/hold control and match outputs per slot. The top level holds the priority logic, FSM and counter.

## Test plan
- Without FORWARD_EN, add x5 followed by add x6,x5,x1 → 3 stall cycles with idex_bubble=1, stall_cnt=3, then issue.
- With FORWARD_EN, lw x7 followed by add x8,x7,x2 → exactly 1 stall cycle. Non-load add x7 followed by a dependent instruction → 0 stalls.
- Producer writes x0, consumer reads x0 → no stall in either configuration.
- ex_branch_taken=1 on the same cycle as a hazard → ifid_flush=1, idex_bubble=1, pc_en=1, and the hazard is dropped.
- mem_busy held 4 cycles during a 2-cycle stall → freeze=1 for 4 cycles with the scoreboard unchanged. The remaining stall cycles resume afterwards, stall_cnt=6.
- rst asserted during STALL → next cycle state=RUN, stall_cnt=0, and the formerly dependent instruction issues without a stall.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and constants for the RV32I hazard controller.
//  Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } slot_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    function automatic logic slot_hit(input slot_t s, input logic [4:0] rs);
        return s.valid && (s.rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Three-slot (EX/MEM/WB) destination tracker with per-slot
//                source-register match against the instruction in ID.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       bubble,
    input  slot_t      issue,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs2,
    output logic       hit_ex,
    output logic       hit_mem,
    output logic       hit_wb,
    output logic       load_hit_ex
);

    slot_t r_ex;
    slot_t r_mem;
    slot_t r_wb;

    // A bubble only empties EX; older instructions keep draining toward WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!hold) begin
            r_ex  <= bubble ? slot_t'('0) : issue;
            r_mem <= r_ex;
            r_wb  <= r_mem;
        end
    end

    assign hit_ex  = id_valid && (slot_hit(r_ex, id_rs1)  || (id_use_rs2 && slot_hit(r_ex, id_rs2)));
    assign hit_mem = id_valid && (slot_hit(r_mem, id_rs1) || (id_use_rs2 && slot_hit(r_mem, id_rs2)));
    assign hit_wb  = id_valid && (slot_hit(r_wb, id_rs1)  || (id_use_rs2 && slot_hit(r_wb, id_rs2)));

    assign load_hit_ex = hit_ex && r_ex.is_load;

    logic w_unused_wb_load;
    assign w_unused_wb_load = r_wb.is_load;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Five-stage pipeline hazard controller: stall/flush/freeze
//                priority, state tracking and saturating stall counter.
//                Define FORWARD_EN when the EX/MEM->EX bypass exists, so only
//                load-use hazards stall.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t            w_issue;
    logic             w_hit_ex;
    logic             w_hit_mem;
    logic             w_hit_wb;
    logic             w_load_hit_ex;
    logic             w_hazard;
    state_t           w_next_state;
    state_t           r_state;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_issue = '{valid:   id_valid && id_reg_write && (id_rd != REG_ZERO),
                       rd:      id_rd,
                       is_load: id_mem_read};

    hazard_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .hold        (mem_busy),
        .bubble      (idex_bubble),
        .issue       (w_issue),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs2  (id_use_rs2),
        .hit_ex      (w_hit_ex),
        .hit_mem     (w_hit_mem),
        .hit_wb      (w_hit_wb),
        .load_hit_ex (w_load_hit_ex)
    );

`ifdef FORWARD_EN
    assign w_hazard = w_load_hit_ex;

    logic w_unused_hits;
    assign w_unused_hits = w_hit_ex ^ w_hit_mem ^ w_hit_wb;
`else
    // Register file writes at the end of WB, so a WB match still has to wait.
    assign w_hazard = w_hit_ex || w_hit_mem || w_hit_wb;

    logic w_unused_hits;
    assign w_unused_hits = w_load_hit_ex;
`endif

    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        freeze       = 1'b0;
        w_next_state = RUN;
        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            // Branch stays parked in EX and is honoured once memory is ready.
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            freeze       = 1'b1;
            w_next_state = FREEZE;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_hazard) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_bubble  = 1'b1;
            w_next_state = STALL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (!pc_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire
